alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// Each op takes IDLE -> EXEC -> DONE: grant pulse in EXEC, done pulse in DONE.
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [2:0]       op0,
  input  logic             s_inm0,
  output logic             gnt0,
  output logic             done0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [2:0]       op1,
  input  logic             s_inm1,
  output logic             gnt1,
  output logic             done1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_s_inm,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  output logic             owner,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic             last_grant_q;
  logic             owner_pending_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [2:0]       opc_q;
  logic             ops_q;
  logic             gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
  logic [WIDTH-1:0] result_q;
  logic [2:0]       flags_q;
  logic             owner_q;

  // Winner for this IDLE edge: the lone requester, or on a tie the one not granted last.
  logic sel_d;
  always_comb begin
    sel_d = req1;
    if (req0 && req1) sel_d = ~last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      last_grant_q    <= 1'b1;
      owner_pending_q <= 1'b0;
      opa_q           <= '0;
      opb_q           <= '0;
      opc_q           <= 3'b000;
      ops_q           <= 1'b0;
      gnt0_q          <= 1'b0;
      gnt1_q          <= 1'b0;
      done0_q         <= 1'b0;
      done1_q         <= 1'b0;
      busy_q          <= 1'b0;
      result_q        <= '0;
      flags_q         <= 3'b000;
      owner_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            state_q         <= EXEC;
            last_grant_q    <= sel_d;
            owner_pending_q <= sel_d;
            opa_q           <= sel_d ? a1 : a0;
            opb_q           <= sel_d ? b1 : b0;
            opc_q           <= sel_d ? op1 : op0;
            ops_q           <= sel_d ? s_inm1 : s_inm0;
            gnt0_q          <= ~sel_d;
            gnt1_q          <= sel_d;
            busy_q          <= 1'b1;
          end
        end
        EXEC: begin
          state_q  <= DONE;
          result_q <= alu_y;
          flags_q  <= {alu_carry, alu_overflow, alu_zero};
          owner_q  <= owner_pending_q;
          done0_q  <= ~owner_pending_q;
          done1_q  <= owner_pending_q;
          gnt0_q   <= 1'b0;
          gnt1_q   <= 1'b0;
          // Operand registers double as the ALU drive, so clearing them idles the ALU inputs.
          opa_q    <= '0;
          opb_q    <= '0;
          opc_q    <= 3'b000;
          ops_q    <= 1'b0;
        end
        DONE: begin
          state_q <= IDLE;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign busy      = busy_q;
  assign alu_a     = opa_q;
  assign alu_b     = opb_q;
  assign alu_op    = opc_q;
  assign alu_s_inm = ops_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stand-in ALU, directed vector table, hand-written
// corner sequences and a randomized run against a cycle-schedule reference model.
module tb_alu_arbiter;
  localparam int W  = 16;
  localparam int NR = 600;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1, s_inm0, s_inm1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [2:0]   op0, op1;
  logic         gnt0, gnt1, done0, done1;
  logic [W-1:0] alu_a, alu_b, alu_y, result;
  logic [2:0]   alu_op, flags;
  logic         alu_s_inm, alu_carry, alu_overflow, alu_zero, owner, busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0), .s_inm0(s_inm0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1), .s_inm1(s_inm1), .gnt1(gnt1), .done1(done1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_s_inm(alu_s_inm),
    .alu_y(alu_y), .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .result(result), .flags(flags), .owner(owner), .busy(busy)
  );

  // Stand-in ALU: s_inm swaps operands; carry mirrors the result msb.
  function automatic logic [W+2:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op, input logic s);
    logic [W-1:0] x, v, y;
    logic ov;
    x  = s ? b : a;
    v  = s ? a : b;
    ov = 1'b0;
    case (op)
      3'b000: y = x & v;
      3'b001: y = x | v;
      3'b010: begin y = x + v; ov = (x[W-1] == v[W-1]) && (y[W-1] != x[W-1]); end
      3'b011: begin y = x - v; ov = (x[W-1] != v[W-1]) && (y[W-1] != x[W-1]); end
      3'b100: y = x ^ v;
      3'b101: y = ~(x | v);
      3'b110: begin y = 16'd0 - x; ov = (x == 16'h8000); end
      default: y = v;
    endcase
    return {y, y[W-1], ov, (y == '0)};
  endfunction

  always_comb begin
    logic [W+2:0] r;
    r = alu_ref(alu_a, alu_b, alu_op, alu_s_inm);
    alu_y        = r[W+2:3];
    alu_carry    = r[2];
    alu_overflow = r[1];
    alu_zero     = r[0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_idle_state(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_gnt"}, {gnt1, gnt0}, 0);
    chk({tag, "_done"}, {done1, done0}, 0);
    chk({tag, "_alu_in"}, {alu_a, alu_b, alu_op, alu_s_inm}, 0);
  endtask

  typedef struct {
    logic         req0;
    logic [W-1:0] a0, b0;
    logic [2:0]   op0;
    logic         s0;
    logic         req1;
    logic [W-1:0] a1, b1;
    logic [2:0]   op1;
    logic         s1;
    logic         exp_w;
    logic [W-1:0] exp_res;
    logic [2:0]   exp_flg;
  } vec_t;

  vec_t vt[6];

  // Random-phase expectations indexed by cycle (posedges since release).
  logic [1:0]   egnt[0:NR+3];
  logic [1:0]   edone[0:NR+3];
  logic         ebusy[0:NR+3];
  logic [W-1:0] ea[0:NR+3];
  logic [W-1:0] eb[0:NR+3];
  logic [2:0]   eop[0:NR+3];
  logic         es[0:NR+3];
  logic [W+2:0] eres[0:NR+3];

  initial begin
    logic [W-1:0] pa[2], pb[2];
    logic [2:0]   po[2];
    logic         ps[2];
    bit           pend[2];
    logic         last_m, own_m, w;
    logic [W-1:0] res_m;
    logic [2:0]   flg_m;
    logic [W+2:0] r;
    int           free_at, e, ngnt0, ngnt1;

    reset = 1'b1;
    req0 = 0; a0 = 0; b0 = 0; op0 = 0; s_inm0 = 0;
    req1 = 0; a1 = 0; b1 = 0; op1 = 0; s_inm1 = 0;

    //                req0 a0       b0       op0     s0    req1 a1       b1       op1     s1    w     res      flg
    vt[0] = '{1'b1, 16'h7FFF, 16'h0001, 3'b010, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 16'h8000, 3'b110};
    vt[1] = '{1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1, 16'h0003, 16'h0005, 3'b011, 1'b0, 1'b1, 16'hFFFE, 3'b100};
    vt[2] = '{1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1, 16'h0003, 16'h0005, 3'b011, 1'b1, 1'b1, 16'h0002, 3'b000};
    vt[3] = '{1'b1, 16'h8000, 16'h0000, 3'b110, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 16'h8000, 3'b110};
    vt[4] = '{1'b1, 16'h0000, 16'h0000, 3'b010, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 16'h0000, 3'b001};
    vt[5] = '{1'b1, 16'hF0F0, 16'hFF00, 3'b000, 1'b0, 1'b1, 16'h00F0, 16'h0F00, 3'b001, 1'b0, 1'b1, 16'h0FF0, 3'b000};

    // Reset values
    do_reset();
    chk_idle_state("rst");
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_owner", owner, 0);

    // Directed table; operands are scrambled in the grant cycle to prove capture.
    for (int i = 0; i < 6; i++) begin
      req0 = vt[i].req0; a0 = vt[i].a0; b0 = vt[i].b0; op0 = vt[i].op0; s_inm0 = vt[i].s0;
      req1 = vt[i].req1; a1 = vt[i].a1; b1 = vt[i].b1; op1 = vt[i].op1; s_inm1 = vt[i].s1;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), {gnt1, gnt0}, vt[i].exp_w ? 2'b10 : 2'b01);
      chk($sformatf("v%0d_busy_exec", i), busy, 1);
      chk($sformatf("v%0d_alu_in", i), {alu_a, alu_b, alu_op, alu_s_inm},
          vt[i].exp_w ? {vt[i].a1, vt[i].b1, vt[i].op1, vt[i].s1}
                      : {vt[i].a0, vt[i].b0, vt[i].op0, vt[i].s0});
      req0 = 0; req1 = 0; a0 = ~a0; b0 = ~b0; a1 = ~a1; b1 = ~b1; op0 = ~op0; op1 = ~op1;
      @(negedge clk);
      chk($sformatf("v%0d_done", i), {done1, done0}, vt[i].exp_w ? 2'b10 : 2'b01);
      chk($sformatf("v%0d_result", i), result, vt[i].exp_res);
      chk($sformatf("v%0d_flags", i), flags, vt[i].exp_flg);
      chk($sformatf("v%0d_owner", i), owner, vt[i].exp_w);
      chk($sformatf("v%0d_alu_done", i), {alu_a, alu_b, alu_op, alu_s_inm}, 0);
      @(negedge clk);
      chk_idle_state($sformatf("v%0d_idle", i));
      chk($sformatf("v%0d_hold", i), result, vt[i].exp_res);
    end

    // Tie from reset: 0,1,0,1 with grants three cycles apart
    do_reset();
    req0 = 1; a0 = 16'h0001; b0 = 16'h0002; op0 = 3'b010; s_inm0 = 0;
    req1 = 1; a1 = 16'h000F; b1 = 16'h0003; op1 = 3'b100; s_inm1 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("tie%0d_gnt", k), {gnt1, gnt0},
          (k % 3 == 1) ? (((k / 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00);
      chk($sformatf("tie%0d_done", k), {done1, done0},
          (k % 3 == 2) ? (((k / 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00);
      if (k % 3 == 2)
        chk($sformatf("tie%0d_result", k), {owner, result},
            ((k / 3) % 2 == 1) ? {1'b1, 16'h000C} : {1'b0, 16'h0003});
    end
    req0 = 0; req1 = 0;

    // Reset while in EXEC: no done, registers cleared, next op served normally
    @(negedge clk);
    req0 = 1; a0 = 16'h1234; b0 = 16'h0001; op0 = 3'b010;
    @(negedge clk);
    chk("midrst_gnt", {gnt1, gnt0}, 2'b01);
    reset = 1; req0 = 0;
    @(negedge clk);
    chk_idle_state("midrst");
    chk("midrst_regs", {result, flags, owner}, 0);
    reset = 0;
    @(negedge clk);
    chk("midrst_nodone", {done1, done0, busy}, 0);
    req0 = 1; a0 = 16'h0005; b0 = 16'h0006; op0 = 3'b010; s_inm0 = 0;
    @(negedge clk);
    chk("post_gnt", {gnt1, gnt0}, 2'b01);
    req0 = 0;
    @(negedge clk);
    chk("post_done", {done1, done0}, 2'b01);
    chk("post_result", {result, flags, owner}, {16'h000B, 3'b000, 1'b0});

    // Randomized run against a schedule model
    for (int c = 0; c <= NR + 3; c++) begin
      egnt[c] = 0; edone[c] = 0; ebusy[c] = 0;
      ea[c] = 0; eb[c] = 0; eop[c] = 0; es[c] = 0; eres[c] = 0;
    end
    do_reset();
    pend[0] = 0; pend[1] = 0;
    last_m = 1; own_m = 0; res_m = 0; flg_m = 0; free_at = 1;
    ngnt0 = 0; ngnt1 = 0;
    for (int rc = 0; rc < NR; rc++) begin
      if (rc > 0) begin
        if (edone[rc] != 2'b00) begin
          res_m = eres[rc][W+2:3];
          flg_m = eres[rc][2:0];
          own_m = edone[rc][1];
        end
        chk("rnd_gnt", {gnt1, gnt0}, egnt[rc]);
        chk("rnd_done", {done1, done0}, edone[rc]);
        chk("rnd_busy", busy, ebusy[rc]);
        chk("rnd_alu_in", {alu_a, alu_b, alu_op, alu_s_inm}, {ea[rc], eb[rc], eop[rc], es[rc]});
        chk("rnd_result", {result, flags, owner}, {res_m, flg_m, own_m});
      end
      for (int q = 0; q < 2; q++) begin
        if (!pend[q]) begin
          pend[q] = ($urandom_range(0, 99) < 45);
          pa[q] = W'($urandom);
          pb[q] = W'($urandom);
          po[q] = 3'($urandom_range(0, 7));
          ps[q] = 1'($urandom_range(0, 1));
        end
      end
      req0 = pend[0]; a0 = pa[0]; b0 = pb[0]; op0 = po[0]; s_inm0 = ps[0];
      req1 = pend[1]; a1 = pa[1]; b1 = pb[1]; op1 = po[1]; s_inm1 = ps[1];
      e = rc + 1;
      if (e >= free_at && (pend[0] || pend[1])) begin
        w = (pend[0] && pend[1]) ? ~last_m : pend[1];
        last_m = w;
        pend[w] = 0;
        if (w) ngnt1++; else ngnt0++;
        r = alu_ref(pa[w], pb[w], po[w], ps[w]);
        egnt[e]      = w ? 2'b10 : 2'b01;
        ebusy[e]     = 1;
        ea[e]        = pa[w];
        eb[e]        = pb[w];
        eop[e]       = po[w];
        es[e]        = ps[w];
        edone[e + 1] = w ? 2'b10 : 2'b01;
        ebusy[e + 1] = 1;
        eres[e + 1]  = r;
        free_at      = e + 3;
      end
      @(negedge clk);
    end
    req0 = 0; req1 = 0;
    chk("rnd_both_served", (ngnt0 > 10) && (ngnt1 > 10), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
